// File: rtl/ds_bypass_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for ds_bypass_stage.
// The decode stage sits on the slave modport and the surrounding pipeline on the master modport.
interface ds_bypass_stage_if #(
    parameter int DATA_W = 32,
    parameter int NRD    = 2,
    parameter int PAY_W  = 64
);
    logic                    fs_to_ds_valid;
    logic                    ds_allowin;
    logic [PAY_W-1:0]        fs_to_ds_bus;
    logic                    es_allowin;
    logic                    ds_to_es_valid;
    logic [PAY_W-1:0]        ds_to_es_payload;
    logic [NRD*DATA_W-1:0]   ds_to_es_operands;

    modport slave (
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  es_allowin,
        output ds_allowin,
        output ds_to_es_valid,
        output ds_to_es_payload,
        output ds_to_es_operands
    );

    modport master (
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output es_allowin,
        input  ds_allowin,
        input  ds_to_es_valid,
        input  ds_to_es_payload,
        input  ds_to_es_operands
    );
endinterface

// File: rtl/ds_bypass_stage.sv
// Decode-stage pipeline register with register file, multi-source operand bypass,
// load-use interlock, flush and a saturating stall-cycle counter.
module ds_bypass_stage #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NRD    = 2,
    parameter int NFWD   = 3,
    parameter int PAY_W  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    ds_bypass_stage_if.slave       pipe,
    output logic [PAY_W-1:0]       ds_payload,
    input  logic [NRD*AW-1:0]      ds_src_addr,
    input  logic [NRD-1:0]         ds_src_need,
    input  logic                   flush,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AW-1:0]     fwd_waddr,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic                   rf_we,
    input  logic [AW-1:0]          rf_waddr,
    input  logic [DATA_W-1:0]      rf_wdata,
    output logic [31:0]            stall_cnt
);
    localparam int NREG = 1 << AW;

    logic              r_ds_valid;
    logic [PAY_W-1:0]  r_payload;
    logic [DATA_W-1:0] r_rf [NREG];
    logic [31:0]       r_stall_cnt;

    logic [NRD-1:0]    w_port_stall;
    logic              w_stall;
    logic              w_ready_go;
    logic              w_allowin;

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_port
            logic [AW-1:0]     w_addr;
            logic [DATA_W-1:0] w_opnd;
            logic              w_sel_ready;

            assign w_addr = ds_src_addr[gi*AW +: AW];

            // Sources are scanned oldest-first so the youngest match wins, readiness included.
            always_comb begin
                w_opnd      = r_rf[w_addr];
                w_sel_ready = 1'b1;
                if (rf_we && (rf_waddr == w_addr)) begin
                    w_opnd = rf_wdata;
                end
                for (int j = NFWD - 1; j >= 0; j--) begin
                    if (fwd_we[j] && (fwd_waddr[j*AW +: AW] == w_addr)) begin
                        w_opnd      = fwd_wdata[j*DATA_W +: DATA_W];
                        w_sel_ready = fwd_ready[j];
                    end
                end
                if (w_addr == '0) begin
                    w_opnd      = '0;
                    w_sel_ready = 1'b1;
                end
            end

            assign pipe.ds_to_es_operands[gi*DATA_W +: DATA_W] = w_opnd;
            assign w_port_stall[gi] = ds_src_need[gi] & ~w_sel_ready;
        end
    endgenerate

    assign w_stall    = |w_port_stall;
    assign w_ready_go = ~w_stall;
    assign w_allowin  = ~r_ds_valid | (w_ready_go & pipe.es_allowin);

    assign pipe.ds_allowin       = w_allowin;
    assign pipe.ds_to_es_valid   = r_ds_valid & w_ready_go & ~flush;
    assign pipe.ds_to_es_payload = r_payload;
    assign ds_payload            = r_payload;
    assign stall_cnt             = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ds_valid <= 1'b0;
            r_payload  <= '0;
        end else begin
            if (flush) begin
                r_ds_valid <= 1'b0;
            end else if (w_allowin) begin
                r_ds_valid <= pipe.fs_to_ds_valid;
            end
            if (pipe.fs_to_ds_valid && w_allowin) begin
                r_payload <= pipe.fs_to_ds_bus;
            end
        end
    end

    // A flushed cycle is not counted even if the killed instruction was stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (r_ds_valid && w_stall && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREG; k++) begin
                r_rf[k] <= '0;
            end
        end else if (rf_we && (rf_waddr != '0)) begin
            r_rf[rf_waddr] <= rf_wdata;
        end
    end
endmodule

// File: tb/tb_ds_bypass_stage.sv
// Directed bench for ds_bypass_stage: vector table for operand resolution plus
// hand-written sequences for latency, load-use, flush, streaming, saturation and reset.
`timescale 1ns/1ps
module tb_ds_bypass_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ds_payload;
    logic [9:0]  ds_src_addr;
    logic [1:0]  ds_src_need;
    logic        flush;
    logic [2:0]  fwd_we;
    logic [14:0] fwd_waddr;
    logic [95:0] fwd_wdata;
    logic [2:0]  fwd_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ds_bypass_stage_if #(.DATA_W(32), .NRD(2), .PAY_W(64)) pipe ();

    ds_bypass_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pipe        (pipe.slave),
        .ds_payload  (ds_payload),
        .ds_src_addr (ds_src_addr),
        .ds_src_need (ds_src_need),
        .flush       (flush),
        .fwd_we      (fwd_we),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .fwd_ready   (fwd_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .stall_cnt   (stall_cnt)
    );

    typedef struct {
        logic [4:0]  a0, a1;
        logic [1:0]  need;
        logic [2:0]  we;
        logic [4:0]  wa0, wa1, wa2;
        logic [2:0]  rdy;
        logic        rfwe;
        logic [4:0]  rfwa;
        logic        es;
        logic [31:0] exp0, exp1;
        logic        expv, expa;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe.fs_to_ds_valid = 1'b0;
        pipe.fs_to_ds_bus   = '0;
        pipe.es_allowin     = 1'b0;
        ds_src_addr = '0;
        ds_src_need = '0;
        flush       = 1'b0;
        fwd_we      = '0;
        fwd_waddr   = '0;
        fwd_ready   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = 32'h22;
    endtask

    task automatic apply_vec(input vec_t v);
        ds_src_addr     = {v.a1, v.a0};
        ds_src_need     = v.need;
        fwd_we          = v.we;
        fwd_waddr       = {v.wa2, v.wa1, v.wa0};
        fwd_ready       = v.rdy;
        rf_we           = v.rfwe;
        rf_waddr        = v.rfwa;
        rf_wdata        = 32'h22;
        pipe.es_allowin = v.es;
    endtask

    task automatic set_load_use();
        ds_src_addr = {5'd7, 5'd0};
        ds_src_need = 2'b10;
        fwd_we      = 3'b011;
        fwd_waddr   = {5'd0, 5'd7, 5'd7};
        fwd_ready   = 3'b010;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, recv, cyc;
        int pat[3];
        logic fire_in, fire_out;
        logic [63:0] out_pl;
        pat = '{1, 0, 1};
        fwd_wdata = {32'h0000_0033, 32'h0000_0044, 32'h0000_0055};

        //                a0    a1    need   we      wa0   wa1   wa2   rdy     rfwe  rfwa  es    exp0          exp1          v     a
        vecs[0]  = '{5'd5, 5'd0, 2'b01, 3'b111, 5'd5, 5'd5, 5'd5, 3'b111, 1'b1, 5'd5, 1'b1, 32'h55,       32'h0,        1'b1, 1'b1};
        vecs[1]  = '{5'd5, 5'd0, 2'b01, 3'b110, 5'd5, 5'd5, 5'd5, 3'b111, 1'b1, 5'd5, 1'b1, 32'h44,       32'h0,        1'b1, 1'b1};
        vecs[2]  = '{5'd5, 5'd0, 2'b01, 3'b000, 5'd5, 5'd5, 5'd5, 3'b111, 1'b1, 5'd5, 1'b1, 32'h22,       32'h0,        1'b1, 1'b1};
        vecs[3]  = '{5'd5, 5'd0, 2'b01, 3'b000, 5'd5, 5'd5, 5'd5, 3'b111, 1'b0, 5'd5, 1'b1, 32'h11,       32'h0,        1'b1, 1'b1};
        vecs[4]  = '{5'd5, 5'd0, 2'b01, 3'b000, 5'd5, 5'd5, 5'd5, 3'b111, 1'b1, 5'd6, 1'b1, 32'h11,       32'h0,        1'b1, 1'b1};
        vecs[5]  = '{5'd0, 5'd7, 2'b10, 3'b011, 5'd7, 5'd7, 5'd0, 3'b010, 1'b0, 5'd0, 1'b1, 32'h0,        32'h55,       1'b0, 1'b0};
        vecs[6]  = '{5'd0, 5'd7, 2'b00, 3'b011, 5'd7, 5'd7, 5'd0, 3'b010, 1'b0, 5'd0, 1'b1, 32'h0,        32'h55,       1'b1, 1'b1};
        vecs[7]  = '{5'd0, 5'd0, 2'b01, 3'b001, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b1};
        vecs[8]  = '{5'd0, 5'd7, 2'b10, 3'b011, 5'd7, 5'd7, 5'd0, 3'b001, 1'b0, 5'd0, 1'b1, 32'h0,        32'h55,       1'b1, 1'b1};
        vecs[9]  = '{5'd0, 5'd7, 2'b10, 3'b010, 5'd0, 5'd7, 5'd0, 3'b000, 1'b0, 5'd0, 1'b1, 32'h0,        32'h44,       1'b0, 1'b0};
        vecs[10] = '{5'd5, 5'd0, 2'b01, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 1'b0, 32'h11,       32'h0,        1'b1, 1'b0};
        vecs[11] = '{5'd5, 5'd7, 2'b11, 3'b001, 5'd7, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 1'b1, 32'h11,       32'h55,       1'b1, 1'b1};
        vecs[12] = '{5'd7, 5'd5, 2'b01, 3'b100, 5'd0, 5'd0, 5'd7, 3'b000, 1'b0, 5'd0, 1'b1, 32'h33,       32'h11,       1'b0, 1'b0};

        // Reset state
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ds_src_addr = {5'd7, 5'd5};
        #1;
        chk("rst_valid",   64'(pipe.ds_to_es_valid), 64'd0);
        chk("rst_allowin", 64'(pipe.ds_allowin), 64'd1);
        chk("rst_payload", pipe.ds_to_es_payload, 64'd0);
        chk("rst_ops",     64'(pipe.ds_to_es_operands), 64'd0);
        chk("rst_cnt",     64'(stall_cnt), 64'd0);

        // Preload r5 = 0x11, r7 = 0x77
        rf_we = 1'b1; rf_waddr = 5'd5; rf_wdata = 32'h11;
        tick();
        rf_waddr = 5'd7; rf_wdata = 32'h77;
        tick();
        idle();

        // One-cycle acceptance latency
        pipe.fs_to_ds_valid = 1'b1;
        pipe.fs_to_ds_bus   = 64'hA5A5_0001_0000_1000;
        tick();
        pipe.fs_to_ds_valid = 1'b0;
        #1;
        chk("lat_valid",   64'(pipe.ds_to_es_valid), 64'd1);
        chk("lat_payload", pipe.ds_to_es_payload, 64'hA5A5_0001_0000_1000);
        chk("lat_dspay",   ds_payload, 64'hA5A5_0001_0000_1000);

        // Operand resolution table on the held instruction
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d_op0", i), 64'(pipe.ds_to_es_operands[31:0]), 64'(vecs[i].exp0));
            chk($sformatf("vec%0d_op1", i), 64'(pipe.ds_to_es_operands[63:32]), 64'(vecs[i].exp1));
            chk($sformatf("vec%0d_valid", i), 64'(pipe.ds_to_es_valid), 64'(vecs[i].expv));
            chk($sformatf("vec%0d_allowin", i), 64'(pipe.ds_allowin), 64'(vecs[i].expa));
            idle();
        end
        chk("tbl_cnt", 64'(stall_cnt), 64'd0);

        // Load-use stall, then release
        @(negedge clk);
        set_load_use();
        pipe.es_allowin = 1'b1;
        #1;
        chk("lu_valid0",   64'(pipe.ds_to_es_valid), 64'd0);
        chk("lu_allowin0", 64'(pipe.ds_allowin), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("lu_cnt%0d", k), 64'(stall_cnt), 64'(k));
            chk($sformatf("lu_valid%0d", k), 64'(pipe.ds_to_es_valid), 64'd0);
        end
        fwd_ready = 3'b011;
        #1;
        chk("lu_rel_valid", 64'(pipe.ds_to_es_valid), 64'd1);
        chk("lu_rel_op1",   64'(pipe.ds_to_es_operands[63:32]), 64'h55);
        chk("lu_rel_allow", 64'(pipe.ds_allowin), 64'd1);
        tick();
        chk("lu_gone", 64'(pipe.ds_to_es_valid), 64'd0);
        chk("lu_cnt_hold", 64'(stall_cnt), 64'd3);
        idle();

        // Flush while stalled with a new payload offered
        pipe.fs_to_ds_valid = 1'b1;
        pipe.fs_to_ds_bus   = 64'h0000_0002_0000_2000;
        tick();
        pipe.fs_to_ds_valid = 1'b0;
        set_load_use();
        fwd_ready = 3'b000;
        tick();
        chk("fl_cnt_pre", 64'(stall_cnt), 64'd4);
        flush = 1'b1;
        pipe.fs_to_ds_valid = 1'b1;
        pipe.fs_to_ds_bus   = 64'h0000_0003_0000_3000;
        #1;
        chk("fl_valid_now", 64'(pipe.ds_to_es_valid), 64'd0);
        tick();
        flush = 1'b0;
        pipe.fs_to_ds_valid = 1'b0;
        #1;
        chk("fl_valid_next", 64'(pipe.ds_to_es_valid), 64'd0);
        chk("fl_allowin",    64'(pipe.ds_allowin), 64'd1);
        chk("fl_cnt",        64'(stall_cnt), 64'd4);
        idle();

        // Same-cycle register write and read
        ds_src_addr = {5'd0, 5'd9};
        rf_we = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_bypass", 64'(pipe.ds_to_es_operands[31:0]), 64'hDEAD_BEEF);
        tick();
        rf_we = 1'b0;
        #1;
        chk("wr_stored", 64'(pipe.ds_to_es_operands[31:0]), 64'hDEAD_BEEF);
        rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'hFFFF_FFFF;
        tick();
        rf_we = 1'b0;
        rf_waddr = 5'd9;
        ds_src_addr = {5'd0, 5'd0};
        #1;
        chk("r0_zero", 64'(pipe.ds_to_es_operands[31:0]), 64'd0);
        idle();

        // Stream 8 payloads under es_allowin 1,0,1
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 8 && cyc < 60) begin
            pipe.fs_to_ds_valid = (sent < 8);
            pipe.fs_to_ds_bus   = 64'hC0DE_0000_0000_0000 | 64'(sent);
            pipe.es_allowin     = (pat[cyc % 3] == 1);
            #1;
            fire_in  = pipe.fs_to_ds_valid & pipe.ds_allowin;
            fire_out = pipe.ds_to_es_valid & pipe.es_allowin;
            out_pl   = pipe.ds_to_es_payload;
            if (fire_out) begin
                chk($sformatf("tp_pay%0d", recv), out_pl, 64'hC0DE_0000_0000_0000 | 64'(recv));
                recv++;
            end
            if (fire_in) sent++;
            tick();
            cyc++;
        end
        chk("tp_count", 64'(recv), 64'd8);
        idle();
        tick();
        chk("tp_drained", 64'(pipe.ds_to_es_valid), 64'd0);

        // Counter saturation
        pipe.fs_to_ds_valid = 1'b1;
        pipe.fs_to_ds_bus   = 64'h0000_0009_0000_9000;
        tick();
        pipe.fs_to_ds_valid = 1'b0;
        set_load_use();
        fwd_ready = 3'b000;
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_stall_cnt;
        tick();
        chk("sat_fe", 64'(stall_cnt), 64'hFFFF_FFFE);
        tick();
        chk("sat_ff", 64'(stall_cnt), 64'hFFFF_FFFF);
        tick();
        chk("sat_hold", 64'(stall_cnt), 64'hFFFF_FFFF);

        // Reset mid-stall
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        ds_src_addr = {5'd7, 5'd5};
        #1;
        chk("rst2_cnt",     64'(stall_cnt), 64'd0);
        chk("rst2_valid",   64'(pipe.ds_to_es_valid), 64'd0);
        chk("rst2_allowin", 64'(pipe.ds_allowin), 64'd1);
        chk("rst2_ops",     64'(pipe.ds_to_es_operands), 64'd0);
        chk("rst2_payload", ds_payload, 64'd0);
        ds_src_addr = {5'd0, 5'd9};
        #1;
        chk("rst2_r9", 64'(pipe.ds_to_es_operands[31:0]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
